// File: rtl/vocab_prefix_matcher.sv
`default_nettype none
// ============================================================================
// Module      : vocab_prefix_matcher
// Description : Scans a vocab RAM one entry per cycle and returns the longest
//               or first entry that is a prefix of the input window.
// Revision    : 1.0 - initial release
// ============================================================================
module vocab_prefix_matcher #(
  parameter int SYM_WIDTH   = 8,
  parameter int MAX_LEN     = 4,
  parameter int VOCAB_DEPTH = 16,
  parameter int ID_WIDTH    = $clog2(VOCAB_DEPTH),
  parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [MAX_LEN*SYM_WIDTH-1:0] win_data,
  input  logic [LEN_WIDTH-1:0]         win_len,
  output logic                         vocab_rd,
  output logic [ID_WIDTH-1:0]          vocab_addr,
  input  logic [MAX_LEN*SYM_WIDTH-1:0] vocab_data,
  input  logic [LEN_WIDTH-1:0]         vocab_len,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [ID_WIDTH-1:0]          tok_id,
  output logic [LEN_WIDTH-1:0]         tok_len
);

  localparam logic [1:0] c_s_idle  = 2'd0;
  localparam logic [1:0] c_s_scan  = 2'd1;
  localparam logic [1:0] c_s_drain = 2'd2;
  localparam logic [1:0] c_s_fin   = 2'd3;

  localparam logic [ID_WIDTH-1:0]  c_last_addr = ID_WIDTH'(VOCAB_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0] c_max_len   = LEN_WIDTH'(MAX_LEN);

  logic [1:0]                   r_state;
  logic                         r_mode;
  logic [MAX_LEN*SYM_WIDTH-1:0] r_win;
  logic [LEN_WIDTH-1:0]         r_wlen;
  logic                         r_cmp_valid;
  logic [ID_WIDTH-1:0]          r_cmp_idx;

  logic [MAX_LEN-1:0] w_sym_ok;
  logic               w_match;
  logic               w_update;
  logic               w_term;
  logic               w_win_bad;

  // Symbols beyond the entry length are don't-care.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_sym
    localparam logic [LEN_WIDTH-1:0] c_idx = LEN_WIDTH'(i);
    assign w_sym_ok[i] = (c_idx >= vocab_len) ||
                         (vocab_data[i*SYM_WIDTH +: SYM_WIDTH] == r_win[i*SYM_WIDTH +: SYM_WIDTH]);
  end

  assign w_match   = (vocab_len != '0) && (vocab_len <= r_wlen) && (&w_sym_ok);
  assign w_update  = r_cmp_valid && w_match && (r_mode || (vocab_len > tok_len));
  // A full-window match cannot be beaten, so longest mode stops there too.
  assign w_term    = w_update && (r_mode || (vocab_len == r_wlen));
  assign w_win_bad = (win_len == '0) || (win_len > c_max_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_s_idle;
      r_mode      <= 1'b0;
      r_win       <= '0;
      r_wlen      <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= '0;
      vocab_rd    <= 1'b0;
      vocab_addr  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      tok_id      <= '0;
      tok_len     <= '0;
    end else begin
      if (w_update) begin
        found   <= 1'b1;
        tok_id  <= r_cmp_idx;
        tok_len <= vocab_len;
      end
      case (r_state)
        c_s_idle: begin
          done        <= 1'b0;
          r_cmp_valid <= 1'b0;
          if (start) begin
            r_mode  <= mode;
            r_win   <= win_data;
            r_wlen  <= win_len;
            found   <= 1'b0;
            tok_id  <= '0;
            tok_len <= '0;
            if (w_win_bad) begin
              r_state <= c_s_fin;
              done    <= 1'b1;
            end else begin
              r_state    <= c_s_scan;
              busy       <= 1'b1;
              vocab_rd   <= 1'b1;
              vocab_addr <= '0;
            end
          end
        end
        c_s_scan: begin
          r_cmp_idx <= vocab_addr;
          if (w_term) begin
            // The read issued this cycle is speculative; its data is dropped.
            r_state     <= c_s_fin;
            r_cmp_valid <= 1'b0;
            vocab_rd    <= 1'b0;
            vocab_addr  <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (vocab_addr == c_last_addr) begin
            r_state     <= c_s_drain;
            r_cmp_valid <= 1'b1;
            vocab_rd    <= 1'b0;
            vocab_addr  <= '0;
          end else begin
            r_cmp_valid <= 1'b1;
            vocab_addr  <= vocab_addr + 1'b1;
          end
        end
        c_s_drain: begin
          r_state     <= c_s_fin;
          r_cmp_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: begin
          r_state <= c_s_idle;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vocab_prefix_matcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_vocab_prefix_matcher
// Description : Directed self-checking bench for vocab_prefix_matcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vocab_prefix_matcher;

  localparam int c_depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] win_data;
  logic [2:0]  win_len;
  logic        vocab_rd;
  logic [3:0]  vocab_addr;
  logic [31:0] vocab_data;
  logic [2:0]  vocab_len;
  logic        busy;
  logic        done;
  logic        found;
  logic [3:0]  tok_id;
  logic [2:0]  tok_len;

  logic [31:0] mem_d [c_depth];
  logic [2:0]  mem_l [c_depth];

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int reads;
  bit saw_done;

  always #5 clk = ~clk;

  vocab_prefix_matcher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .win_data   (win_data),
    .win_len    (win_len),
    .vocab_rd   (vocab_rd),
    .vocab_addr (vocab_addr),
    .vocab_data (vocab_data),
    .vocab_len  (vocab_len),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .tok_id     (tok_id),
    .tok_len    (tok_len)
  );

  // Synchronous-read vocab RAM: data valid the cycle after vocab_rd.
  always @(posedge clk) begin
    if (vocab_rd) begin
      vocab_data <= mem_d[vocab_addr];
      vocab_len  <= mem_l[vocab_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < c_depth; i++) begin
      mem_d[i] = 32'hA5A5_A5A5;
      mem_l[i] = 3'd0;
    end
  endtask

  // Issues one start; lat counts cycles after the sampling edge until done.
  task automatic run(input logic m, input logic [31:0] w, input logic [2:0] wl,
                     input int extra_at, input int rst_at);
    @(negedge clk);
    start = 1'b1; mode = m; win_data = w; win_len = wl;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; reads = 0; saw_done = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (vocab_rd) reads++;
      if (done) begin saw_done = 1'b1; break; end
      if (lat == extra_at) begin start = 1'b1; mode = ~m; end
      if (lat == extra_at + 1) start = 1'b0;
      if (lat == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd", vocab_rd, 0);
        check_eq("rst_addr", vocab_addr, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        check_eq("rst_hold_done", done, 0);
        rst = 1'b0;
        break;
      end
      if (lat > 100) begin
        check_eq("timeout", lat, 0);
        break;
      end
    end
    if (saw_done) begin
      @(negedge clk);
      check_eq("done_pulse", done, 0);
      check_eq("idle_busy", busy, 0);
    end
  endtask

  task automatic vocab_a();
    clear_mem();
    mem_d[0] = 32'hFFFF_FF61; mem_l[0] = 3'd1;
    mem_d[3] = 32'hFFFF_6261; mem_l[3] = 3'd2;
    mem_d[7] = 32'hFF63_6261; mem_l[7] = 3'd3;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; win_data = '0; win_len = '0;
    vocab_data = '0; vocab_len = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_found", found, 0);
    check_eq("reset_id", tok_id, 0);
    check_eq("reset_len", tok_len, 0);
    check_eq("reset_rd", vocab_rd, 0);
    rst = 1'b0;

    // Longest match over a full scan.
    vocab_a();
    run(1'b0, 32'h7863_6261, 3'd4, -1, -1);
    check_eq("long_lat", lat, 18);
    check_eq("long_found", found, 1);
    check_eq("long_id", tok_id, 7);
    check_eq("long_len", tok_len, 3);
    check_eq("long_reads", reads, 16);
    @(negedge clk);
    check_eq("long_hold_id", tok_id, 7);

    // First-match mode stops at entry 0.
    run(1'b1, 32'h7863_6261, 3'd4, -1, -1);
    check_eq("first_lat", lat, 3);
    check_eq("first_id", tok_id, 0);
    check_eq("first_len", tok_len, 1);
    check_eq("first_reads", reads, 2);

    // Full-window match ends the scan; tie keeps lowest index.
    clear_mem();
    mem_d[2] = 32'h0000_4241; mem_l[2] = 3'd2;
    mem_d[5] = 32'h0000_4241; mem_l[5] = 3'd2;
    run(1'b0, 32'h0000_4241, 3'd2, -1, -1);
    check_eq("tie_lat", lat, 5);
    check_eq("tie_id", tok_id, 2);
    check_eq("tie_len", tok_len, 2);
    check_eq("tie_reads", reads, 4);

    // All slots empty.
    clear_mem();
    run(1'b0, 32'h7863_6261, 3'd4, -1, -1);
    check_eq("empty_lat", lat, 18);
    check_eq("empty_found", found, 0);
    check_eq("empty_id", tok_id, 0);

    // Invalid window lengths.
    vocab_a();
    run(1'b0, 32'h7863_6261, 3'd0, -1, -1);
    check_eq("wl0_lat", lat, 1);
    check_eq("wl0_reads", reads, 0);
    check_eq("wl0_found", found, 0);
    run(1'b0, 32'h7863_6261, 3'd5, -1, -1);
    check_eq("wl5_lat", lat, 1);
    check_eq("wl5_reads", reads, 0);

    // Entry longer than the window never matches.
    clear_mem();
    mem_d[4] = 32'h0063_6261; mem_l[4] = 3'd3;
    run(1'b0, 32'h0000_6261, 3'd2, -1, -1);
    check_eq("short_found", found, 0);
    check_eq("short_len", tok_len, 0);
    check_eq("short_lat", lat, 18);

    // Start during a search (with the other mode) must be ignored.
    vocab_a();
    run(1'b0, 32'h7863_6261, 3'd4, 4, -1);
    check_eq("busy_start_lat", lat, 18);
    check_eq("busy_start_id", tok_id, 7);

    // Reset mid-scan, then a clean search.
    run(1'b0, 32'h7863_6261, 3'd4, -1, 6);
    check_eq("rst_no_done", saw_done, 0);
    check_eq("rst_found", found, 0);
    run(1'b1, 32'h7863_6261, 3'd4, -1, -1);
    check_eq("after_rst_lat", lat, 3);
    check_eq("after_rst_id", tok_id, 0);
    check_eq("after_rst_found", found, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
